// File: rtl/klotski_pkg.sv
// Shared types and constants for the klotski camera pipeline blocks.
package klotski_pkg;

  localparam int NUM_BLOCKS = 16;

  typedef logic [23:0] rgb_t;
  typedef logic [63:0] order_t;
  typedef logic [NUM_BLOCKS-1:0] block_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SORT,
    ST_WAIT,
    ST_CHECK
  } scan_state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_PERM    = 2'd2;

  // One-hot decode of a 4-bit block / tile number.
  function automatic block_mask_t tile_onehot(input logic [3:0] n);
    block_mask_t m;
    m    = '0;
    m[n] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/board_scan_ctrl_perm_check.sv
// Combinational check that a 16-nibble sort order is a permutation of 0..15.
module order_perm_check
  import klotski_pkg::*;
(
  input  order_t i_order,
  output logic   o_valid
);

  block_mask_t seen;

  // Union of the one-hot tile decodes; every tile present exactly once iff full
  always_comb begin
    seen = '0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      seen = seen | tile_onehot(i_order[4*k +: 4]);
    end
    o_valid = &seen;
  end

endmodule

// File: rtl/board_scan_ctrl.sv
// Frame sequencer for the RGBSort classifier: gathers 16 block colours,
// launches a sort, validates the returned order and publishes a board once
// the same order has been seen on STABLE_FRAMES consecutive frames.
module board_scan_ctrl
  import klotski_pkg::*;
#(
  parameter int STABLE_FRAMES = 3,
  parameter int SORT_TIMEOUT  = 1023
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_color_valid,
  input  logic [3:0]                  i_color_idx,
  input  logic [23:0]                 i_color,
  output logic [NUM_BLOCKS*24-1:0]    o_blocks,
  output logic                        o_sort_start,
  input  logic                        i_sort_done,
  input  logic [63:0]                 i_sort_order,
  output logic [63:0]                 o_board,
  output logic                        o_board_valid,
  output logic                        o_busy,
  output logic                        o_error,
  output logic [1:0]                  o_err_code
);

  localparam int TO_W = $clog2(SORT_TIMEOUT + 1);
  localparam int ST_W = $clog2(STABLE_FRAMES + 1);

  // The counter value seen in the last WAIT cycle before a timeout fires.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SORT_TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STABLE_FRAMES);

  scan_state_e                 state_q, state_d;
  block_mask_t                 mask_q, mask_d;
  rgb_t [NUM_BLOCKS-1:0]       blocks_q, blocks_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic [ST_W-1:0]             stab_cnt_q, stab_cnt_d;
  order_t                      order_q, order_d;
  order_t                      cand_q, cand_d;
  logic                        cand_vld_q, cand_vld_d;
  order_t                      board_q, board_d;
  logic                        published_q, published_d;
  logic                        sort_start_q, sort_start_d;
  logic                        board_valid_q, board_valid_d;
  logic                        busy_q, busy_d;
  logic                        error_q, error_d;
  logic [1:0]                  err_code_q, err_code_d;
  logic                        perm_ok;

  order_perm_check u_perm_check (
    .i_order (order_q),
    .o_valid (perm_ok)
  );

  // Next-state and next-output computation for the scan sequencer
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    blocks_d      = blocks_q;
    to_cnt_d      = to_cnt_q;
    stab_cnt_d    = stab_cnt_q;
    order_d       = order_q;
    cand_d        = cand_q;
    cand_vld_d    = cand_vld_q;
    board_d       = board_q;
    published_d   = published_q;
    board_valid_d = 1'b0;
    error_d       = 1'b0;
    err_code_d    = err_code_q;

    if (!i_enable) begin
      // Disable overrides everything, including a sort completing this cycle.
      state_d    = ST_IDLE;
      mask_d     = '0;
      stab_cnt_d = '0;
      cand_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COLLECT;
          mask_d  = '0;
        end

        ST_COLLECT: begin
          if (i_color_valid) begin
            blocks_d[i_color_idx] = i_color;
            mask_d = mask_q | tile_onehot(i_color_idx);
            if (&mask_d) begin
              state_d = ST_SORT;
            end
          end
        end

        ST_SORT: begin
          to_cnt_d = '0;
          state_d  = ST_WAIT;
        end

        ST_WAIT: begin
          // A completion in the same cycle as the timeout takes precedence.
          if (i_sort_done) begin
            order_d = i_sort_order;
            state_d = ST_CHECK;
          end else if (to_cnt_q == TO_LAST) begin
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            mask_d     = '0;
            state_d    = ST_COLLECT;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          mask_d  = '0;
          state_d = ST_COLLECT;
          if (!perm_ok) begin
            error_d    = 1'b1;
            err_code_d = ERR_PERM;
            stab_cnt_d = '0;
            cand_vld_d = 1'b0;
          end else begin
            if (cand_vld_q && (order_q == cand_q)) begin
              stab_cnt_d = (stab_cnt_q == ST_MAX) ? ST_MAX : stab_cnt_q + 1'b1;
            end else begin
              cand_d     = order_q;
              cand_vld_d = 1'b1;
              stab_cnt_d = ST_W'(1);
            end
            // Republish only on a change, or for the very first board.
            if ((stab_cnt_d == ST_MAX) && ((cand_d != board_q) || !published_q)) begin
              board_d       = cand_d;
              published_d   = 1'b1;
              board_valid_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          mask_d  = '0;
        end
      endcase
    end

    sort_start_d = (state_d == ST_SORT);
    busy_d       = (state_d inside {ST_SORT, ST_WAIT, ST_CHECK});
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      blocks_q      <= '0;
      to_cnt_q      <= '0;
      stab_cnt_q    <= '0;
      order_q       <= '0;
      cand_q        <= '0;
      cand_vld_q    <= 1'b0;
      board_q       <= '0;
      published_q   <= 1'b0;
      sort_start_q  <= 1'b0;
      board_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      blocks_q      <= blocks_d;
      to_cnt_q      <= to_cnt_d;
      stab_cnt_q    <= stab_cnt_d;
      order_q       <= order_d;
      cand_q        <= cand_d;
      cand_vld_q    <= cand_vld_d;
      board_q       <= board_d;
      published_q   <= published_d;
      sort_start_q  <= sort_start_d;
      board_valid_q <= board_valid_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign o_blocks      = blocks_q;
  assign o_sort_start  = sort_start_q;
  assign o_board       = board_q;
  assign o_board_valid = board_valid_q;
  assign o_busy        = busy_q;
  assign o_error       = error_q;
  assign o_err_code    = err_code_q;

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Testbench for board_scan_ctrl: table of order sequences with hand-derived
// expectations, hand-written disable/reset/timeout/duplicate sequences, and
// randomized frames checked against a run-history reference model.
module tb_board_scan_ctrl;

  localparam int SF = 3;
  localparam int TO = 15;

  localparam logic [63:0] ORD_A   = 64'h0123456789ABCDEF;
  localparam logic [63:0] ORD_B   = 64'h0123456789ABCDFE;
  localparam logic [63:0] ORD_C   = 64'h1032547698BADCFE;
  localparam logic [63:0] ORD_D   = 64'hFEDCBA9876543210;
  localparam logic [63:0] ORD_BAD = 64'h0123456789ABCDEE;

  logic         clk = 1'b0;
  logic         rst_n, en, cvld, sdone;
  logic [3:0]   cidx;
  logic [23:0]  col;
  logic [383:0] blocks;
  logic         sstart, bvld, busy, err;
  logic [63:0]  sorder, board;
  logic [1:0]   ecode;

  board_scan_ctrl #(.STABLE_FRAMES(SF), .SORT_TIMEOUT(TO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .i_color_valid (cvld),
    .i_color_idx   (cidx),
    .i_color       (col),
    .o_blocks      (blocks),
    .o_sort_start  (sstart),
    .i_sort_done   (sdone),
    .i_sort_order  (sorder),
    .o_board       (board),
    .o_board_valid (bvld),
    .o_busy        (busy),
    .o_error       (err),
    .o_err_code    (ecode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int bv_seen = 0;

  logic [23:0]  exp_blk [16];
  logic [63:0]  m_board;
  logic         m_pub;
  logic [1:0]   m_code;
  logic [63:0]  hist [$];

  typedef struct {
    logic [63:0] ord;
    int          dly;
    logic        pub;
    logic        er;
    logic [1:0]  code;
    logic [63:0] brd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bvld === 1'b1) bv_seen++;
  endtask

  function automatic logic [383:0] exp_pack();
    logic [383:0] v;
    for (int k = 0; k < 16; k++) v[24*k +: 24] = exp_blk[k];
    return v;
  endfunction

  function automatic bit is_perm(input logic [63:0] o);
    int cnt [16];
    for (int t = 0; t < 16; t++) cnt[t] = 0;
    for (int k = 0; k < 16; k++) cnt[o[4*k +: 4]]++;
    for (int t = 0; t < 16; t++) if (cnt[t] != 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] rand_perm();
    int p [16];
    logic [63:0] o;
    for (int k = 0; k < 16; k++) p[k] = k;
    for (int k = 15; k > 0; k--) begin
      int j;
      int t;
      j = int'($urandom_range(0, k));
      t = p[k]; p[k] = p[j]; p[j] = t;
    end
    for (int k = 0; k < 16; k++) o[4*k +: 4] = 4'(p[k]);
    return o;
  endfunction

  task automatic model_reset();
    m_board = '0;
    m_pub   = 1'b0;
    m_code  = 2'd0;
    hist.delete();
    for (int k = 0; k < 16; k++) exp_blk[k] = '0;
  endtask

  // Expected outcome of one sort, from the published rules on order history.
  task automatic model_step(input logic [63:0] o, input int dly,
                            output logic pub, output logic er, output logic [1:0] code);
    pub = 1'b0;
    er  = 1'b0;
    if (dly >= TO) begin
      er = 1'b1;
      m_code = 2'd1;
    end else if (!is_perm(o)) begin
      er = 1'b1;
      m_code = 2'd2;
      hist.delete();
    end else begin
      bit same;
      hist.push_back(o);
      same = (hist.size() >= SF);
      if (same) begin
        for (int i = hist.size() - SF; i < hist.size(); i++) if (hist[i] != o) same = 1'b0;
      end
      if (same && (!m_pub || m_board != o)) begin
        pub = 1'b1;
        m_board = o;
        m_pub = 1'b1;
      end
    end
    code = m_code;
  endtask

  task automatic drive(input logic [3:0] idx, input logic [23:0] c);
    cvld = 1'b1;
    cidx = idx;
    col  = c;
    exp_blk[idx] = c;
  endtask

  task automatic junk();
    cvld = 1'b1;
    cidx = 4'($urandom);
    col  = 24'($urandom);
  endtask

  // Sends all 16 indices (style 1: shuffled, with duplicates and gaps).
  task automatic collect_frame(input int style);
    logic [63:0] seq;
    seq = 64'hFEDCBA9876543210;
    if (style != 0) seq = rand_perm();
    for (int k = 0; k < 16; k++) begin
      if (style != 0 && k > 0 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          int j;
          j = int'($urandom_range(0, k - 1));
          drive(seq[4*j +: 4], 24'($urandom));
        end else begin
          cvld = 1'b0;
        end
        tick();
        chk("start_early", sstart, 0);
      end
      drive(seq[4*k +: 4], 24'($urandom));
      tick();
      chk("sort_start", sstart, (k == 15));
    end
    chk("busy_sort", busy, 1);
    chk("blocks_sort", blocks, exp_pack());
  endtask

  // Entered in the SORT cycle; answers after dly WAIT cycles (or never).
  task automatic respond(input string nm, input logic [63:0] o, input int dly,
                         input logic e_pub, input logic e_err, input logic [1:0] e_code,
                         input logic [63:0] e_board);
    tick();
    cvld = 1'b0;
    if (dly >= TO) begin
      repeat (TO - 1) tick();
      chk({nm, "_to_early"}, err, 0);
      tick();
    end else begin
      repeat (dly) tick();
      sdone  = 1'b1;
      sorder = o;
      tick();
      sdone  = 1'b0;
      sorder = {$urandom, $urandom};
      chk({nm, "_chk_busy"}, busy, 1);
      chk({nm, "_chk_bv"}, bvld, 0);
      chk({nm, "_chk_err"}, err, 0);
      tick();
    end
    chk({nm, "_bv"}, bvld, e_pub);
    chk({nm, "_err"}, err, e_err);
    chk({nm, "_code"}, ecode, e_code);
    chk({nm, "_board"}, board, e_board);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_blocks"}, blocks, exp_pack());
  endtask

  task automatic frame_model(input string nm, input int style, input logic [63:0] o, input int dly);
    logic p;
    logic e;
    logic [1:0] c;
    collect_frame(style);
    junk();
    model_step(o, dly, p, e, c);
    respond(nm, o, dly, p, e, c, m_board);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_blocks"}, blocks, 0);
    chk({nm, "_board"}, board, 0);
    chk({nm, "_code"}, ecode, 0);
    chk({nm, "_start"}, sstart, 0);
    chk({nm, "_bv"}, bvld, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] prev;
    rst_n = 1'b0; en = 1'b1; cvld = 1'b0; cidx = '0; col = '0;
    sdone = 1'b0; sorder = '0;
    model_reset();

    tbl[0]  = '{ORD_A,   0,  1'b0, 1'b0, 2'd0, 64'h0};
    tbl[1]  = '{ORD_A,   1,  1'b0, 1'b0, 2'd0, 64'h0};
    tbl[2]  = '{ORD_A,   3,  1'b1, 1'b0, 2'd0, ORD_A};
    tbl[3]  = '{ORD_A,   0,  1'b0, 1'b0, 2'd0, ORD_A};
    tbl[4]  = '{ORD_C,   14, 1'b0, 1'b0, 2'd0, ORD_A};
    tbl[5]  = '{ORD_C,   2,  1'b0, 1'b0, 2'd0, ORD_A};
    tbl[6]  = '{ORD_B,   0,  1'b0, 1'b0, 2'd0, ORD_A};
    tbl[7]  = '{ORD_C,   5,  1'b0, 1'b0, 2'd0, ORD_A};
    tbl[8]  = '{ORD_C,   1,  1'b0, 1'b0, 2'd0, ORD_A};
    tbl[9]  = '{ORD_C,   0,  1'b1, 1'b0, 2'd0, ORD_C};
    tbl[10] = '{ORD_D,   7,  1'b0, 1'b0, 2'd0, ORD_C};
    tbl[11] = '{ORD_D,   0,  1'b0, 1'b0, 2'd0, ORD_C};
    tbl[12] = '{ORD_BAD, 2,  1'b0, 1'b1, 2'd2, ORD_C};
    tbl[13] = '{ORD_D,   4,  1'b0, 1'b0, 2'd2, ORD_C};
    tbl[14] = '{ORD_D,   0,  1'b0, 1'b0, 2'd2, ORD_C};
    tbl[15] = '{ORD_D,   14, 1'b1, 1'b0, 2'd2, ORD_D};

    repeat (3) tick();
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      collect_frame(i % 2);
      junk();
      respond($sformatf("vec%0d", i), tbl[i].ord, tbl[i].dly, tbl[i].pub,
              tbl[i].er, tbl[i].code, tbl[i].brd);
    end
    chk("pub_count", bv_seen, 3);

    // Disable during WAIT, then a late completion
    collect_frame(0);
    cvld = 1'b0;
    tick();
    en = 1'b0;
    tick();
    chk("dis_busy", busy, 0);
    sdone = 1'b1; sorder = ORD_A;
    tick();
    chk("dis_late_busy", busy, 0);
    chk("dis_late_bv", bvld, 0);
    sdone = 1'b0;
    tick();
    chk("dis_board", board, ORD_D);
    chk("dis_bv", bvld, 0);
    chk("dis_err", err, 0);
    en = 1'b1;
    tick();

    // Disable in the same cycle as completion
    collect_frame(0);
    cvld = 1'b0;
    tick();
    en = 1'b0; sdone = 1'b1; sorder = ORD_A;
    tick();
    chk("dis_sim_busy", busy, 0);
    sdone = 1'b0;
    tick();
    chk("dis_sim_bv", bvld, 0);
    chk("dis_sim_board", board, ORD_D);
    en = 1'b1;
    tick();

    // Reset during WAIT, then a late completion
    collect_frame(0);
    cvld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk_zero("rst_wait");
    rst_n = 1'b1; sdone = 1'b1; sorder = ORD_A;
    tick();
    chk("rst_late_busy", busy, 0);
    sdone = 1'b0;
    tick();
    chk("rst_late_bv", bvld, 0);
    chk("rst_late_board", board, 0);
    model_reset();

    // Timeout, then the following frame must be accepted
    frame_model("timeout", 1, ORD_A, TO);
    frame_model("after_to", 0, ORD_C, 3);

    // Descending indices with index 3 repeated
    for (int i = 15; i >= 0; i--) begin
      drive(4'(i), 24'($urandom));
      tick();
      chk("dup_start", sstart, (i == 0));
      if (i == 3) begin
        drive(4'd3, 24'h7f0000);
        tick();
        chk("dup_start3", sstart, 0);
      end
    end
    chk("dup_slot3", blocks[95:72], 24'h7f0000);
    chk("dup_blocks", blocks, exp_pack());
    begin
      logic p;
      logic e;
      logic [1:0] c;
      junk();
      model_step(ORD_A, 2, p, e, c);
      respond("dup", ORD_A, 2, p, e, c, m_board);
    end

    // Randomized frames against the reference model
    prev = ORD_A;
    for (int f = 0; f < 40; f++) begin
      logic [63:0] o;
      int dly;
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 4)      o = prev;
      else if (r == 5) o = ORD_A;
      else if (r == 6) o = ORD_C;
      else if (r == 7) o = rand_perm();
      else if (r == 8) o = {$urandom, $urandom};
      else             o = ORD_BAD;
      if ($urandom_range(0, 7) == 0) dly = TO + int'($urandom_range(0, 2));
      else                           dly = int'($urandom_range(0, TO - 1));
      prev = o;
      frame_model($sformatf("rnd%0d", f), 1, o, dly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
